switchbank_fifo_poll: RTL and testbench
=======================================

Name: switchbank_fifo_poll

Overview:
Parametrised successor to the single-entry polled switch-bank peripheral. A debounced press of the enter key captures the switch bank into a DEPTH-entry FIFO. The CPU polls a status word (a0=1) or reads the FIFO head (a0=0), and pops with ack. An optional level interrupt supports IRQ-driven firmware. It sits on the CPU I/O bus alongside the other memory-mapped devices.

Parameters:
DATA_W, 16, switch-bank and data_out width; legal range 8..32.
DEPTH, 4, FIFO entries; power of two, 2..16.
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a key level; legal range 1..255.
IRQ_EN, 0, 1 drives irq from FIFO non-empty; 0 ties irq low.

Ports:
clk  input  1  single system clock; all logic is on posedge.
reset  input  1  synchronous, active-high reset.
switches  input  DATA_W  raw switch bank; sampled at capture.
enter_key  input  1  raw, asynchronous, active-low push button.
a0  input  1  register select: 1 = status, 0 = data.
ack  input  1  CPU read strobe, one cycle per access.
data_out  output  DATA_W  combinational read mux.
irq  output  1  level interrupt request.

Behaviour:
- Reset (sync, high): FIFO empty (rd_ptr=wr_ptr=0, count=0), overflow flag=0, sync/debounce state set to released (1), debounce counter=0. After reset: irq=0 and data_out=0 in both a0 modes.
- Key path:
  - 2-flop synchroniser on enter_key.
  - Debouncer: the stable level changes only after DEBOUNCE_CYCLES consecutive identical synchronised samples that differ from the current stable level. Any mismatching sample clears the counter.
  - Press event = stable level transitions 1->0. This is a single-cycle pulse. Release generates no event.
  - Latency from an enter_key fall to the push is 2 + DEBOUNCE_CYCLES clk cycles (±1 cycle of synchroniser sampling).
- Push: on a press event, if not full, write switches into mem[wr_ptr], increment wr_ptr (wraps mod DEPTH), and increment count.
- Push when full: the entry is dropped, overflow is set (sticky), and FIFO contents are unchanged.
- Pop: ack & !a0 with count>0 advances rd_ptr (wraps) and decrements count. Pop when empty is ignored.
- Simultaneous push and pop in the same cycle:
  - Both take effect; count is unchanged.
  - When full, the push is accepted because the pop frees the slot; overflow is not set.
  - When empty, only the push takes effect; the pop is ignored.
- Status read: ack & a0 clears overflow at the clock edge. If an overflowing push happens in the same cycle, set wins.
- data_out, combinational:
  - a0=1: status word, zero-extended to DATA_W. Bit0 = nonempty, bit1 = full, bit2 = overflow, bits[7:3] = count (0..16), remaining bits 0.
  - a0=0: mem[rd_ptr] when nonempty, else 0.
- irq = IRQ_EN ? nonempty : 0. It is registered-state driven, so it has no combinational path from ack.
- No other state; holding ack high pops once per cycle.

Decomposition:
- Package switchbank_pkg:
  - STAT_NONEMPTY=0, STAT_FULL=1, STAT_OVF=2, STAT_CNT_LSB=3, STAT_CNT_W=5 bit-index constants.
  - typedef of the 8-bit status struct (packed) shared with the firmware header generator.
- Sub-module key_debounce (params DEBOUNCE_CYCLES; ports clk, reset, key_n, press_pulse) holds the synchroniser, counter and edge detect.
- The FIFO stays inline in the top module.

Test Plan:
1. Reset then idle -> a0=1 data_out=0, a0=0 data_out=0, irq=0.
2. DEBOUNCE_CYCLES=4; switches=16'hA5C3; enter_key low for 10 cycles, then high -> exactly one push. Status reads 16'h0009 (count=1, nonempty). The a0=0 read returns A5C3. A pop with ack&!a0 makes status read 0.
3. Bounce: enter_key toggles every 2 cycles for 20 cycles, then stays high -> no push; count stays 0.
4. DEPTH=4: five clean presses with switches=1,2,3,4,5 -> status 16'h0027 (count=4, full, overflow, nonempty). The pops then return 1,2,3,4. The status read with ack clears overflow.
5. Full FIFO; a press pulse coincides with ack&!a0 -> count stays 4, overflow stays 0, and the new value lands at the tail.
6. IRQ_EN=1: one press -> irq rises within the latency bound. Reset asserted mid-debounce with count=2 -> next-cycle status reads 0, irq=0, and no spurious push after reset releases.

Source files
------------

// File: rtl/switchbank_pkg.sv
// Shared definitions for the switch-bank FIFO peripheral: status-word bit
// positions and the packed status layout used by the firmware header generator.
package switchbank_pkg;

    localparam int STAT_NONEMPTY = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_OVF      = 2;
    localparam int STAT_CNT_LSB  = 3;
    localparam int STAT_CNT_W    = 5;

    // Declared MSB first so the fields land at bits [7:3], 2, 1, 0.
    typedef struct packed {
        logic [STAT_CNT_W-1:0] count;
        logic                  overflow;
        logic                  full;
        logic                  nonempty;
    } status_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces the active-low enter key and emits a single-cycle
// pulse when the accepted level falls from released (1) to pressed (0).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);

    logic       sync1_q, sync2_q;
    logic       stable_q, stable_d;
    logic [7:0] cnt_q, cnt_d;
    logic       differ;
    logic       settle;

    // The counter tracks how many consecutive samples disagree with the
    // accepted level; the level flips on the last one of the run.
    always_comb begin
        differ   = (sync2_q != stable_q);
        settle   = differ && (cnt_q == 8'(DEBOUNCE_CYCLES - 1));
        stable_d = stable_q;
        cnt_d    = 8'd0;
        if (settle) begin
            stable_d = sync2_q;
        end else if (differ) begin
            cnt_d = cnt_q + 8'd1;
        end
        press_pulse = settle && stable_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= 8'd0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/switchbank_fifo_poll.sv
// Polled switch-bank peripheral: each debounced key press captures the switches
// into a small FIFO that the CPU drains through a status/data register pair.
module switchbank_fifo_poll
    import switchbank_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IRQ_EN          = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] switches,
    input  logic              enter_key,
    input  logic              a0,
    input  logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic    press;
    logic    nonempty, full, push, pop, ovf_set;
    status_t status;
    logic [7:0] status_bits;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk        (clk),
        .reset      (reset),
        .key_n      (enter_key),
        .press_pulse(press)
    );

    // A pop in the same cycle frees the slot, so a press into a full FIFO
    // is only dropped when nothing is being read out.
    always_comb begin
        nonempty = (count_q != '0);
        full     = (count_q == CNT_W'(DEPTH));
        pop      = ack && !a0 && nonempty;
        push     = press && (!full || pop);
        ovf_set  = press && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ack && a0) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= switches;
        end
    end

    always_comb begin
        status.count    = STAT_CNT_W'(count_q);
        status.overflow = ovf_q;
        status.full     = full;
        status.nonempty = nonempty;
        status_bits     = status;
        if (a0) begin
            data_out = DATA_W'(status_bits);
        end else if (nonempty) begin
            data_out = mem_q[rd_ptr_q];
        end else begin
            data_out = '0;
        end
    end

    assign irq = (IRQ_EN != 0) ? nonempty : 1'b0;

endmodule

// File: tb/tb_switchbank_fifo_poll.sv
// Directed testbench for switchbank_fifo_poll: a vector table for the FIFO
// drain sequence plus hand-written sequences for debounce and reset corners.
module tb_switchbank_fifo_poll;

    logic        clk;
    logic        reset;
    logic [15:0] switches;
    logic        enterKey;
    logic        a0;
    logic        ack;
    logic [15:0] dataOut;
    logic        irq;
    logic [15:0] dataOutNoIrq;
    logic        irqNoIrq;

    int checkCount;
    int errorCount;

    typedef struct {
        logic        a0;
        logic        ack;
        logic [15:0] expData;
        logic        expIrq;
    } vec_t;

    vec_t vecs [11];

    switchbank_fifo_poll #(
        .DATA_W(16), .DEPTH(4), .DEBOUNCE_CYCLES(4), .IRQ_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .switches(switches), .enter_key(enterKey),
        .a0(a0), .ack(ack), .data_out(dataOut), .irq(irq)
    );

    // Second instance sees identical stimulus but has its interrupt disabled.
    switchbank_fifo_poll #(
        .DATA_W(16), .DEPTH(4), .DEBOUNCE_CYCLES(4), .IRQ_EN(0)
    ) dutNoIrq (
        .clk(clk), .reset(reset), .switches(switches), .enter_key(enterKey),
        .a0(a0), .ack(ack), .data_out(dataOutNoIrq), .irq(irqNoIrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic a0V, input logic ackV);
        a0  = a0V;
        ack = ackV;
        #1;
    endtask

    task automatic readExpect(input string name, input logic a0V, input logic [15:0] expected);
        applyStimulus(a0V, 1'b0);
        checkOutput(name, 32'(dataOut), 32'(expected));
    endtask

    task automatic popOnce();
        applyStimulus(1'b0, 1'b1);
        step(1);
        ack = 1'b0;
    endtask

    task automatic pressKey(input logic [15:0] value);
        switches = value;
        enterKey = 1'b0;
        step(10);
        enterKey = 1'b1;
        step(10);
    endtask

    task automatic doReset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        bit irqSeen;

        checkCount = 0;
        errorCount = 0;
        reset      = 1'b1;
        switches   = 16'h0000;
        enterKey   = 1'b1;
        a0         = 1'b0;
        ack        = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 16'h0027, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 16'h0027, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 16'h0023, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 16'h0001, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 16'h0002, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 16'h0003, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 16'h0004, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0};

        // Reset and idle
        doReset();
        step(3);
        readExpect("reset_status", 1'b1, 16'h0000);
        readExpect("reset_data", 1'b0, 16'h0000);
        checkOutput("reset_irq", 32'(irq), 32'd0);

        // Single clean press, read back, pop
        pressKey(16'hA5C3);
        readExpect("one_press_status", 1'b1, 16'h0009);
        readExpect("one_press_data", 1'b0, 16'hA5C3);
        popOnce();
        readExpect("after_pop_status", 1'b1, 16'h0000);

        // Bouncing key never holds a level for four samples
        for (int i = 0; i < 10; i++) begin
            enterKey = ~enterKey;
            step(2);
        end
        enterKey = 1'b1;
        step(10);
        readExpect("bounce_status", 1'b1, 16'h0000);

        // Five presses into a four-deep FIFO, then drain through the table
        for (int i = 1; i <= 5; i++) begin
            pressKey(16'(i));
        end
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].a0, vecs[i].ack);
            checkOutput($sformatf("vec%0d_data", i), 32'(dataOut), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].expIrq));
            checkOutput($sformatf("vec%0d_data_noirq", i), 32'(dataOutNoIrq), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_irq_noirq", i), 32'(irqNoIrq), 32'd0);
            step(1);
            ack = 1'b0;
        end

        // Full FIFO: press pulse lands on the same edge as a pop.
        // The pulse is high in the cycle before the (2+DEBOUNCE_CYCLES)th edge.
        for (int i = 11; i <= 14; i++) begin
            pressKey(16'(i));
        end
        readExpect("full_status", 1'b1, 16'h0023);
        switches = 16'h000F;
        enterKey = 1'b0;
        step(5);
        applyStimulus(1'b0, 1'b1);
        checkOutput("coincide_head", 32'(dataOut), 32'h0000_000B);
        step(1);
        ack      = 1'b0;
        enterKey = 1'b1;
        step(10);
        readExpect("coincide_status", 1'b1, 16'h0023);
        for (int i = 12; i <= 15; i++) begin
            readExpect($sformatf("coincide_pop_%0d", i), 1'b0, 16'(i));
            popOnce();
        end
        readExpect("coincide_drained", 1'b1, 16'h0000);

        // Interrupt latency and reset in the middle of a debounce
        doReset();
        step(2);
        enterKey = 1'b0;
        irqSeen  = 1'b0;
        for (int i = 0; i < 7 && !irqSeen; i++) begin
            step(1);
            if (irq) irqSeen = 1'b1;
        end
        checkOutput("irq_within_latency", 32'(irqSeen), 32'd1);
        checkOutput("irq_noirq_tied_low", 32'(irqNoIrq), 32'd0);
        enterKey = 1'b1;
        step(10);
        pressKey(16'h0002);
        readExpect("two_entries_status", 1'b1, 16'h0011);
        enterKey = 1'b0;
        step(3);
        reset    = 1'b1;
        enterKey = 1'b1;
        step(1);
        readExpect("midreset_status", 1'b1, 16'h0000);
        checkOutput("midreset_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        step(15);
        readExpect("postreset_status", 1'b1, 16'h0000);
        readExpect("postreset_data", 1'b0, 16'h0000);
        checkOutput("postreset_irq", 32'(irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
